decode_operand_stage: RTL and testbench
=======================================

// Module: decode_operand_stage
// PURPOSE
//  Decode/operand-issue pipeline stage: accepts 32-bit instruction words, decodes them, and registers
//  the fields the execute stage consumes (literal, alusrc, alu_op, register indices, control).
//  Producer end of the ALU B-operand select path: its literal/alusrc outputs drive the B-source mux.
//  One registered slot with a valid/ready handshake on both sides, plus stall, flush and issue count.
// PARAMETERS
//  DATA_W   32  instruction/literal width (fixed at 32; parameterised for the bench only)
//  CNT_W    32  width of issued-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   instruction word present on in_instr
//  in_ready   out  1   stage can accept this cycle
//  in_instr   in   32  [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm16, [5:0] funct
//  flush      in   1   kill registered slot and any instruction accepted this cycle
//  out_valid  out  1   registered decode result valid
//  out_ready  in   1   execute stage consumes result this cycle
//  literal    out  32  extended immediate for ALU B-source mux
//  alusrc     out  1   1 = ALU B takes literal, 0 = register B data
//  alu_op     out  4   ADD=0 SUB=1 AND=2 OR=3 SLT=4 PASSB=5
//  rs_idx     out  5   register A read index
//  rt_idx     out  5   register B read index
//  dest_idx   out  5   write-back register index
//  regwrite   out  1   write-back enable
//  memread    out  1   load
//  memwrite   out  1   store
//  illegal    out  1   unknown opcode/funct
//  issue_cnt  out  CNT_W  count of output handshakes
// BEHAVIOUR
//  - Reset: out_valid=0, every decoded output=0, issue_cnt=0; an instruction in flight is discarded.
//  - in_ready = !out_valid || out_ready (combinational). Load when in_valid && in_ready; latency 1 cycle.
//  - Stall: out_valid && !out_ready -> all outputs hold bit-exact; in_ready=0; in_instr not sampled.
//  - Flush (priority over load): next cycle out_valid=0; in_ready stays as formula, word accepted
//    the same cycle is dropped; issue_cnt not incremented for a flushed slot. rst beats flush.
//  - issue_cnt += 1 on out_valid && out_ready && !flush; wraps to 0 from all-ones.
//  - Slot state: EMPTY (out_valid=0) / FULL (out_valid=1). EMPTY->FULL on load; FULL->FULL on
//    simultaneous consume+load; FULL->EMPTY on consume with no load, or on flush.
//  - Decode table (opcode):
//    0x00 R-type: alusrc=0, literal=0, dest=rd, regwrite=1; funct 0x20 ADD,0x22 SUB,0x24 AND,
//         0x25 OR,0x2A SLT; other funct -> illegal.
//    0x08 ADDI: literal=sext(imm16), ADD, dest=rt, regwrite=1, alusrc=1.
//    0x0C ANDI / 0x0D ORI: literal=zext(imm16), AND/OR, dest=rt, regwrite=1, alusrc=1.
//    0x0F LUI: literal={imm16,16'h0}, PASSB, dest=rt, regwrite=1, alusrc=1.
//    0x23 LW: sext, ADD, dest=rt, regwrite=1, memread=1, alusrc=1.
//    0x2B SW: sext, ADD, regwrite=0, memwrite=1, alusrc=1, dest=0.
//    other: illegal=1, regwrite=memread=memwrite=alusrc=0, literal=0, alu_op=ADD; still issued.
//  - Illegal results are issued (out_valid=1) so the trap logic downstream sees them in order.
// STRUCTURE
//  - Package decode_pkg: opcode/funct localparams, alu_op encodings, field bit-position constants.
//  - Sub-module imm_extend (combinational): imm16 + mode {SEXT,ZEXT,UPPER,ZERO} -> 32-bit literal.
//  - Top: combinational decoder, one output register bank, handshake/flush logic, counter.
// TESTING
//  1 rst=1 two cycles -> out_valid=0, literal=0, alusrc=0, issue_cnt=0, in_ready=1.
//  2 ADDI 0x2021FFFC, out_ready=1 -> next cycle literal=0xFFFFFFFC, alusrc=1, alu_op=0, dest=1, regwrite=1.
//  3 ORI 0x34228000 then LUI 0x3C031234 -> literal 0x00008000 (OR), then 0x12340000 (PASSB), dest=3.
//  4 R-type 0x00221820 -> alusrc=0, literal=0, rs=1, rt=2, dest=3, alu_op=ADD; SW 0xAC220010 -> memwrite=1, regwrite=0, literal=0x10.
//  5 FULL with out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, outputs unchanged; release -> next word loads, issue_cnt +1.
//  6 flush with in_valid=1 -> out_valid=0 next cycle, issue_cnt unchanged; opcode 0x3F -> illegal=1, regwrite=0; preload cnt all-ones -> wraps to 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings for the decode/operand-issue stage: opcodes, functs,
// ALU operation codes, immediate-extension modes and instruction field positions.
package decode_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Instruction field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_PASSB = 4'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'd0,
    IMM_ZEXT  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_ZERO  = 2'd3
  } imm_mode_e;

  // Output slot occupancy; FULL is exactly out_valid
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Decoded control fields registered alongside the literal
  typedef struct packed {
    logic       alusrc;
    logic [3:0] alu_op;
    logic [4:0] rs_idx;
    logic [4:0] rt_idx;
    logic [4:0] dest_idx;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extender: turns imm16 into the ALU B-source literal.
module imm_extend
  import decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [15:0]       imm16,
  input  imm_mode_e         mode,
  output logic [DATA_W-1:0] literal
);

  // Select the extension flavour requested by the decoder
  always_comb begin
    literal = '0;
    unique case (mode)
      IMM_SEXT:  literal = {{(DATA_W-16){imm16[15]}}, imm16};
      IMM_ZEXT:  literal = {{(DATA_W-16){1'b0}}, imm16};
      IMM_UPPER: literal = {imm16, {(DATA_W-16){1'b0}}};
      IMM_ZERO:  literal = '0;
      default:   literal = '0;
    endcase
  end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode/operand-issue stage: decodes one instruction word per handshake into a
// single registered slot feeding execute (literal/alusrc drive the ALU B mux).
// Handshake: a transfer happens on a side in any cycle where valid && ready are
// both high; in_ready = !out_valid || out_ready, so a consumed slot can be
// refilled in the same cycle, and a stalled slot holds every output bit-exact.
module decode_operand_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] literal,
  output logic              alusrc,
  output logic [3:0]        alu_op,
  output logic [4:0]        rs_idx,
  output logic [4:0]        rt_idx,
  output logic [4:0]        dest_idx,
  output logic              regwrite,
  output logic              memread,
  output logic              memwrite,
  output logic              illegal,
  output logic [CNT_W-1:0]  issue_cnt
);

  slot_state_e       state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] literal_q, literal_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;

  ctrl_t             dec_ctrl;
  imm_mode_e         dec_mode;
  logic [DATA_W-1:0] dec_literal;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              load;
  logic              consume;

  assign opcode = in_instr[OPC_MSB:OPC_LSB];
  assign funct  = in_instr[FN_MSB:FN_LSB];

  assign out_valid = (state_q == SLOT_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign load      = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Decode the incoming word into control fields and an extension mode
  always_comb begin
    dec_ctrl          = '0;
    dec_ctrl.alu_op   = ALU_ADD;
    dec_ctrl.rs_idx   = in_instr[RS_MSB:RS_LSB];
    dec_ctrl.rt_idx   = in_instr[RT_MSB:RT_LSB];
    dec_mode          = IMM_ZERO;
    unique case (opcode)
      OP_RTYPE: begin
        dec_ctrl.dest_idx = in_instr[RD_MSB:RD_LSB];
        dec_ctrl.regwrite = 1'b1;
        unique case (funct)
          FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
          FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
          FN_AND:  dec_ctrl.alu_op = ALU_AND;
          FN_OR:   dec_ctrl.alu_op = ALU_OR;
          FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
          default: begin
            // Unknown funct: issue as a harmless no-write so only the trap acts on it
            dec_ctrl.illegal  = 1'b1;
            dec_ctrl.regwrite = 1'b0;
            dec_ctrl.dest_idx = '0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_mode          = IMM_SEXT;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.dest_idx = in_instr[RT_MSB:RT_LSB];
        dec_ctrl.regwrite = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dec_mode          = IMM_ZEXT;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.alu_op   = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        dec_ctrl.dest_idx = in_instr[RT_MSB:RT_LSB];
        dec_ctrl.regwrite = 1'b1;
      end
      OP_LUI: begin
        dec_mode          = IMM_UPPER;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.alu_op   = ALU_PASSB;
        dec_ctrl.dest_idx = in_instr[RT_MSB:RT_LSB];
        dec_ctrl.regwrite = 1'b1;
      end
      OP_LW: begin
        dec_mode          = IMM_SEXT;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.dest_idx = in_instr[RT_MSB:RT_LSB];
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.memread  = 1'b1;
      end
      OP_SW: begin
        dec_mode          = IMM_SEXT;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.memwrite = 1'b1;
      end
      default: begin
        dec_ctrl.illegal = 1'b1;
      end
    endcase
  end

  imm_extend #(.DATA_W(DATA_W)) u_imm_extend (
    .imm16   (in_instr[IMM_MSB:IMM_LSB]),
    .mode    (dec_mode),
    .literal (dec_literal)
  );

  // Slot next-state and register-bank updates; flush outranks load
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    literal_d   = literal_q;
    issue_cnt_d = issue_cnt_q;
    if (consume && !flush) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
    if (flush) begin
      state_d = SLOT_EMPTY;
    end else if (load) begin
      state_d   = SLOT_FULL;
      ctrl_d    = dec_ctrl;
      literal_d = dec_literal;
    end else if (consume) begin
      state_d = SLOT_EMPTY;
    end
  end

  // State, output bank and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SLOT_EMPTY;
      ctrl_q      <= '0;
      literal_q   <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      literal_q   <= literal_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign literal   = literal_q;
  assign alusrc    = ctrl_q.alusrc;
  assign alu_op    = ctrl_q.alu_op;
  assign rs_idx    = ctrl_q.rs_idx;
  assign rt_idx    = ctrl_q.rt_idx;
  assign dest_idx  = ctrl_q.dest_idx;
  assign regwrite  = ctrl_q.regwrite;
  assign memread   = ctrl_q.memread;
  assign memwrite  = ctrl_q.memwrite;
  assign illegal   = ctrl_q.illegal;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage; counter narrowed to 4 bits so the
// wrap from all-ones is reachable in a few handshakes.
module tb_decode_operand_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] literal;
  logic              alusrc;
  logic [3:0]        alu_op;
  logic [4:0]        rs_idx;
  logic [4:0]        rt_idx;
  logic [4:0]        dest_idx;
  logic              regwrite;
  logic              memread;
  logic              memwrite;
  logic              illegal;
  logic [CNT_W-1:0]  issue_cnt;

  int n_cmp;
  int n_bad;

  decode_operand_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .literal   (literal),
    .alusrc    (alusrc),
    .alu_op    (alu_op),
    .rs_idx    (rs_idx),
    .rt_idx    (rt_idx),
    .dest_idx  (dest_idx),
    .regwrite  (regwrite),
    .memread   (memread),
    .memwrite  (memwrite),
    .illegal   (illegal),
    .issue_cnt (issue_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point lands 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word (inputs settle before the in_ready check)
  task automatic drive(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;

    // 1: reset
    step();
    step();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_literal", literal, 0);
    check_val("rst_alusrc", alusrc, 0);
    check_val("rst_issue_cnt", issue_cnt, 0);
    check_val("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // 2: ADDI r1 = r1 + -4
    drive(1, 32'h2021FFFC, 1, 0);
    step();
    check_val("addi_valid", out_valid, 1);
    check_val("addi_literal", literal, 64'hFFFFFFFC);
    check_val("addi_alusrc", alusrc, 1);
    check_val("addi_alu_op", alu_op, 0);
    check_val("addi_dest", dest_idx, 1);
    check_val("addi_regwrite", regwrite, 1);
    check_val("addi_cnt", issue_cnt, 0);

    // 3: ORI then LUI back to back (each cycle consumes the previous result)
    drive(1, 32'h34228000, 1, 0);
    step();
    check_val("ori_literal", literal, 64'h00008000);
    check_val("ori_alu_op", alu_op, 3);
    check_val("ori_dest", dest_idx, 2);
    check_val("ori_cnt", issue_cnt, 1);
    drive(1, 32'h3C031234, 1, 0);
    step();
    check_val("lui_literal", literal, 64'h12340000);
    check_val("lui_alu_op", alu_op, 5);
    check_val("lui_dest", dest_idx, 3);
    check_val("lui_cnt", issue_cnt, 2);

    // 4: R-type ADD r3 = r1 + r2, then SW
    drive(1, 32'h00221820, 1, 0);
    step();
    check_val("radd_alusrc", alusrc, 0);
    check_val("radd_literal", literal, 0);
    check_val("radd_rs", rs_idx, 1);
    check_val("radd_rt", rt_idx, 2);
    check_val("radd_dest", dest_idx, 3);
    check_val("radd_alu_op", alu_op, 0);
    check_val("radd_regwrite", regwrite, 1);
    drive(1, 32'hAC220010, 1, 0);
    step();
    check_val("sw_memwrite", memwrite, 1);
    check_val("sw_regwrite", regwrite, 0);
    check_val("sw_literal", literal, 64'h10);
    check_val("sw_dest", dest_idx, 0);
    check_val("sw_cnt", issue_cnt, 4);

    // 5: stall three cycles with an LW waiting on the input
    drive(1, 32'h8C450004, 0, 0);
    check_val("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_valid", out_valid, 1);
      check_val("stall_memwrite", memwrite, 1);
      check_val("stall_literal", literal, 64'h10);
      check_val("stall_in_ready", in_ready, 0);
      check_val("stall_cnt", issue_cnt, 4);
    end
    drive(1, 32'h8C450004, 1, 0);
    check_val("release_in_ready", in_ready, 1);
    step();
    check_val("lw_literal", literal, 64'h4);
    check_val("lw_memread", memread, 1);
    check_val("lw_dest", dest_idx, 5);
    check_val("lw_rs", rs_idx, 2);
    check_val("lw_cnt", issue_cnt, 5);

    // 6a: flush kills the slot and the word offered alongside it
    drive(1, 32'h2021FFFC, 1, 1);
    check_val("flush_in_ready", in_ready, 1);
    step();
    check_val("flush_valid", out_valid, 0);
    check_val("flush_cnt", issue_cnt, 5);

    // 6b: unknown opcode is still issued, marked illegal
    drive(1, 32'hFC000000, 1, 0);
    step();
    check_val("ill_valid", out_valid, 1);
    check_val("ill_illegal", illegal, 1);
    check_val("ill_regwrite", regwrite, 0);
    check_val("ill_alusrc", alusrc, 0);
    check_val("ill_literal", literal, 0);
    check_val("ill_cnt", issue_cnt, 5);

    // 6c: unknown R-type funct
    drive(1, 32'h00221821, 1, 0);
    step();
    check_val("fn_illegal", illegal, 1);
    check_val("fn_cnt", issue_cnt, 6);

    // 6d: stream until the 4-bit counter reaches all-ones, then wrap
    drive(1, 32'h2021FFFC, 1, 0);
    for (int i = 0; i < 9; i++) step();
    check_val("cnt_all_ones", issue_cnt, 15);
    check_val("cnt_addi_illegal", illegal, 0);
    step();
    check_val("cnt_wrap", issue_cnt, 0);

    // Drain: last result consumed, nothing new loaded
    drive(0, 32'h0, 1, 0);
    step();
    check_val("drain_valid", out_valid, 0);
    check_val("drain_cnt", issue_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
